// File: rtl/zymason_pkg.sv
// rtl/zymason_pkg.sv - shared state encoding and field widths for the Tiny1 loader
package zymason_pkg;

    localparam int SEG_W = 7;
    localparam int NIB_W = 4;
    localparam int SPD_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        FETCH = 3'd2,
        LO    = 3'd3,
        HI    = 3'd4,
        ADV   = 3'd5,
        SCAN  = 3'd6
    } state_t;

endpackage

// File: rtl/zymason_tiny_loader.sv
// rtl/zymason_tiny_loader.sv - streams a frame of 7-seg patterns into a Tiny1 digit store
module zymason_tiny_loader
    import zymason_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SEG_W-1:0] seg_data,
    input  logic             seg_valid,
    output logic             seg_ready,
    input  logic [SPD_W-1:0] scan_spd,
    output logic             tgt_reset,
    output logic             tgt_rw,
    output logic             tgt_sel,
    output logic [NIB_W-1:0] tgt_pin,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t           state;
    state_t           state_next;
    logic [SEG_W-1:0] seg_q;
    logic [IDX_W-1:0] dig_idx;
    logic             done_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Segment latch, digit counter and the one-shot marking entry into SCAN
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q   <= '0;
            dig_idx <= '0;
            done_q  <= 1'b0;
        end else begin
            if (state == FETCH && seg_valid) begin
                seg_q <= seg_data;
            end
            if (state == RST) begin
                dig_idx <= '0;
            end else if (state == ADV) begin
                dig_idx <= dig_idx + 1'b1;
            end
            done_q <= (state == HI) && (dig_idx == LAST_IDX);
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RST;
            RST:     state_next = FETCH;
            FETCH:   if (seg_valid) state_next = LO;
            LO:      state_next = HI;
            HI:      state_next = (dig_idx < LAST_IDX) ? ADV : SCAN;
            ADV:     state_next = FETCH;
            SCAN:    if (start) state_next = RST;
            default: state_next = IDLE;
        endcase
    end

    // Moore output decode; ADV repeats the low nibble because the target rewrites it while advancing
    always_comb begin
        tgt_reset = reset;
        tgt_rw    = 1'b0;
        tgt_sel   = 1'b0;
        tgt_pin   = '0;
        seg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RST: begin
                tgt_reset = 1'b1;
                busy      = 1'b1;
            end
            FETCH: begin
                tgt_rw    = 1'b1;
                tgt_pin   = seg_q[NIB_W-1:0];
                seg_ready = 1'b1;
                busy      = 1'b1;
            end
            LO, ADV: begin
                tgt_rw  = 1'b1;
                tgt_pin = seg_q[NIB_W-1:0];
                busy    = 1'b1;
            end
            HI: begin
                tgt_rw  = 1'b1;
                tgt_sel = 1'b1;
                tgt_pin = {1'b0, seg_q[SEG_W-1:NIB_W]};
                busy    = 1'b1;
            end
            SCAN: begin
                tgt_sel = scan_spd[0];
                tgt_pin = scan_spd[SPD_W-1:1];
                done    = done_q;
            end
            default: begin
                tgt_rw = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_zymason_tiny_loader.sv
// tb/tb_zymason_tiny_loader.sv - self-checking bench with a behavioural Tiny1 digit-store responder
module tb_zymason_tiny_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] seg_data;
    logic       seg_valid;
    logic       seg_ready;
    logic [4:0] scan_spd;
    logic       tgt_reset;
    logic       tgt_rw;
    logic       tgt_sel;
    logic [3:0] tgt_pin;
    logic       busy;
    logic       done;

    zymason_tiny_loader #(.NUM_DIGITS(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .seg_data  (seg_data),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .scan_spd  (scan_spd),
        .tgt_reset (tgt_reset),
        .tgt_rw    (tgt_rw),
        .tgt_sel   (tgt_sel),
        .tgt_pin   (tgt_pin),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Target responder: write low nibble on sel=0, high bits on sel=1; a sel 1->0 step advances
    logic [6:0] tdig [2];
    int         tptr = 0;
    bit         thi = 1'b0;
    logic [3:0] last_lo = '0;
    logic [6:0] sb [$];
    int         done_cnt = 0;
    logic [6:0] sb_exp;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (tgt_reset === 1'b1) begin
            tptr = 0;
            thi  = 1'b0;
        end else if (tgt_rw === 1'b1) begin
            if (tgt_sel === 1'b0) begin
                tdig[tptr][3:0] = tgt_pin;
                last_lo = tgt_pin;
                if (thi && tptr < 1) tptr++;
                thi = 1'b0;
            end else begin
                tdig[tptr][6:4] = tgt_pin[2:0];
                thi = 1'b1;
                if (sb.size() > 0) begin
                    sb_exp = sb.pop_front();
                    chk("sb_digit", {25'd0, tgt_pin[2:0], last_lo}, {25'd0, sb_exp});
                end else begin
                    chk("sb_underflow", sb.size(), 1);
                end
            end
        end else begin
            thi = 1'b0;
        end
    end

    task automatic run_frame(input logic [6:0] a, input logic [6:0] b, input int stall,
                             input bit start_lo, output int lat);
        logic [6:0] fq [2];
        int idx;
        int st;
        bit hs;
        fq[0] = a;
        fq[1] = b;
        idx   = 0;
        st    = stall;
        lat   = -1;
        sb.delete();
        sb.push_back(a);
        sb.push_back(b);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cnt = 1; cnt < 100 && lat < 0; cnt++) begin
            hs        = 1'b0;
            seg_valid = 1'b0;
            seg_data  = 7'h55;
            if (seg_ready === 1'b1 && idx < 2) begin
                if (idx == 1 && st > 0) begin
                    st--;
                    chk("stall_rw", tgt_rw, 1);
                    chk("stall_sel", tgt_sel, 0);
                end else begin
                    seg_valid = 1'b1;
                    seg_data  = fq[idx];
                    hs        = 1'b1;
                end
            end
            step();
            start = 1'b0;
            if (hs) begin
                idx++;
                if (idx == 1 && start_lo) start = 1'b1;
            end
            if (done === 1'b1) lat = cnt + 1;
        end
        seg_valid = 1'b0;
    endtask

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        int         stall;
        bit         start_lo;
        logic [4:0] spd;
        logic [3:0] pin;
        logic       sel;
        int         lat;
    } vec_t;

    vec_t vt [4];
    int   lat;
    int   dc;
    bit   found;
    int   idx;
    bit   hs;

    initial begin
        vt[0] = '{7'h3F, 7'h06, 0, 1'b0, 5'b00000, 4'h0, 1'b0, 9};
        vt[1] = '{7'h3F, 7'h06, 5, 1'b0, 5'b10110, 4'hB, 1'b0, 14};
        vt[2] = '{7'h5B, 7'h4F, 0, 1'b1, 5'b00001, 4'h0, 1'b1, 9};
        vt[3] = '{7'h7F, 7'h00, 0, 1'b0, 5'b11111, 4'hF, 1'b1, 9};

        reset     = 1'b1;
        start     = 1'b0;
        seg_valid = 1'b0;
        seg_data  = '0;
        scan_spd  = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tgt_reset", tgt_reset, 1);
            chk("rst_tgt_rw", tgt_rw, 0);
            chk("rst_seg_ready", seg_ready, 0);
            chk("rst_busy", busy, 0);
        end
        reset = 1'b0;
        step();
        chk("idle_tgt_reset", tgt_reset, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_pin", tgt_pin, 0);

        for (int v = 0; v < 4; v++) begin
            scan_spd = vt[v].spd;
            run_frame(vt[v].a, vt[v].b, vt[v].stall, vt[v].start_lo, lat);
            chk("latency", lat, vt[v].lat);
            chk("digit0", tdig[0], vt[v].a);
            chk("digit1", tdig[1], vt[v].b);
            chk("sb_drained", sb.size(), 0);
            step();
            chk("done_one_cycle", done, 0);
            chk("scan_rw", tgt_rw, 0);
            chk("scan_sel", tgt_sel, vt[v].sel);
            chk("scan_pin", tgt_pin, vt[v].pin);
            chk("scan_busy", busy, 0);
        end

        // Reset during HI of the last digit discards the frame and suppresses done
        sb.delete();
        sb.push_back(7'h12);
        sb.push_back(7'h34);
        found = 1'b0;
        idx   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cnt = 0; cnt < 40 && !found; cnt++) begin
            hs        = 1'b0;
            seg_valid = 1'b0;
            if (seg_ready === 1'b1 && idx < 2) begin
                seg_valid = 1'b1;
                seg_data  = (idx == 0) ? 7'h12 : 7'h34;
                hs        = 1'b1;
            end
            step();
            seg_valid = 1'b0;
            if (hs) idx++;
            if (idx == 2 && tgt_rw === 1'b1 && tgt_sel === 1'b1) begin
                reset = 1'b1;
                found = 1'b1;
            end
        end
        chk("mid_reset_reached", found, 1);
        dc = done_cnt;
        step();
        chk("mid_tgt_reset", tgt_reset, 1);
        chk("mid_busy", busy, 0);
        chk("mid_seg_ready", seg_ready, 0);
        reset = 1'b0;
        step();
        chk("mid_idle_tgt_reset", tgt_reset, 0);
        chk("mid_idle_busy", busy, 0);
        chk("mid_idle_rw", tgt_rw, 0);
        repeat (12) step();
        chk("mid_no_done", done_cnt, dc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
